norm_result_collector: RTL and testbench
========================================

// Module: norm_result_collector
// PURPOSE
//  Downstream stage of the 4-lane vector normaliser (A,B,C,D / sqrt(A^2+B^2+C^2+D^2)).
//  Captures the four divider quotients when all lanes are valid together and saturates each to DATAWIDTH bits.
//  Buffers results in a FIFO and presents them on a valid/ready port.
//  Issues credit (launch_ok) so the source never launches more vectors than the FIFO can absorb.
// PARAMETERS
//  DATAWIDTH  16  lane width of the normaliser inputs; quotients arrive as DATAWIDTH+1 bits
//  DEPTH       8  result FIFO entries; power of 2, >=2
// PORTS
//  clk           input   1              clock, all state on rising edge
//  rst           input   1              asynchronous, active-low reset (0 = reset)
//  launch        input   1              source pulses this with the normaliser i_valid (one vector launched)
//  launch_ok     output  1              credit available; source may launch this cycle
//  q_valid       input   4              per-lane quotient valid {D,C,B,A}
//  q_a..q_d      input   DATAWIDTH+1    per-lane quotient, unsigned
//  m_valid       output  1              result available
//  m_ready       input   1              downstream accepts result
//  m_data        output  4*DATAWIDTH    {D,C,B,A} saturated quotients
//  m_sat         output  4              per-lane saturation flags for m_data {D,C,B,A}
//  clr_err       input   1              synchronous clear of sticky errors
//  err_mismatch  output  1              sticky: q_valid was neither 4'b0000 nor 4'b1111
//  err_overflow  output  1              sticky: capture attempted while FIFO full and not popping
//  err_credit    output  1              sticky: launch asserted while launch_ok low
// BEHAVIOUR
//  - Reset: FIFO empty, inflight=0, m_valid=0, m_data=0, m_sat=0, all err_*=0, launch_ok=1.
//  - Capture happens only when q_valid==4'b1111.
//    - Any partial q_valid sets err_mismatch; nothing is written.
//  - Saturation, per lane: if q[DATAWIDTH]==1, data = all ones and sat bit = 1.
//    Otherwise data = q[DATAWIDTH-1:0] and sat bit = 0.
//  - FIFO write on capture; pop on m_valid&&m_ready.
//    - Full with a pop in the same cycle: the write is accepted and count is unchanged.
//    - Full with no pop: the write is dropped and err_overflow is set.
//    - Empty: no pop; m_valid stays 0.
//  - Latency: a capture at edge N gives m_valid=1 after edge N. No combinational q->m path (no fall-through).
//  - m_data and m_sat are driven from the FIFO head. They hold stable while m_valid && !m_ready.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
//  - inflight counter, log2(DEPTH)+1 bits:
//    - +1 on launch, -1 on capture; both in the same cycle leaves it unchanged.
//    - Saturates at 0 when a capture occurs with inflight==0 (e.g. a result arriving after reset).
//    - Saturates at max.
//  - launch_ok = (count + inflight) < DEPTH, decoded combinationally from registers only.
//  - A launch while launch_ok==0 sets err_credit and is still counted.
//  - Errors: clr_err clears all sticky bits next edge. An error event in the same cycle as clr_err wins (bit stays 1).
//  - Reset mid-operation: all state returns to reset values immediately (asynchronously).
//    Quotients still in the normaliser pipeline are captured normally afterwards if space exists.
// STRUCTURE
//  - Package norm_pkg:
//    - NUM_LANES=4
//    - typedef lane_q_t  (logic [DATAWIDTH:0])
//    - typedef lane_t    (logic [DATAWIDTH-1:0])
//    - typedef struct packed norm_result_t {logic [3:0] sat; lane_t [3:0] data;}
//    - function sat_lane()
//  - Sub-module sync_fifo #(WIDTH, DEPTH): register array, wr/rd pointers, count, full/empty.
//  - Top level holds capture/saturation, the inflight counter, the credit compare and the error flags.
// TESTING
//  1. Reset, then one vector: q_a=17'h00B50 and q_b=q_c=q_d=17'h0, all valid, m_ready=1
//     -> next cycle m_valid=1, m_data[15:0]=16'h0B50, m_sat=0.
//  2. q_b=17'h1_0001 -> m_data lane B=16'hFFFF, m_sat=4'b0010.
//  3. m_ready=0, 8 launches then 8 captures -> launch_ok=0 after the 8th launch.
//     A 9th capture sets err_overflow. Then m_ready=1 drains 8 results in order and launch_ok=1.
//  4. Full FIFO, capture and pop in the same cycle -> count stays 8, no error, order preserved.
//  5. q_valid=4'b0111 -> no write, err_mismatch=1. Then clr_err -> 0 next cycle.
//  6. rst low for 1 cycle with 3 entries and inflight=2 -> m_valid=0, launch_ok=1, counters 0.
//     A late capture is then stored and inflight stays 0.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared types and the per-lane saturation helper for the vector normaliser result path.
package norm_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 16;

    typedef logic [LANE_W:0]   lane_q_t;
    typedef logic [LANE_W-1:0] lane_t;

    typedef struct packed {
        logic [NUM_LANES-1:0] sat;
        lane_t [NUM_LANES-1:0] data;
    } norm_result_t;

    typedef struct packed {
        logic  sat;
        lane_t data;
    } lane_sat_t;

    // A quotient with its top bit set cannot be represented in LANE_W bits; clamp to all ones.
    function automatic lane_sat_t sat_lane(input lane_q_t q);
        lane_sat_t r;
        if (q[LANE_W]) begin
            r.sat  = 1'b1;
            r.data = '1;
        end else begin
            r.sat  = 1'b0;
            r.data = q[LANE_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock register FIFO with head-of-queue read port (no fall-through).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_wr;
    logic             do_rd;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

    // A pop frees the slot the concurrent write needs, so full only blocks a lone write.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/norm_result_collector.sv
// Collects the four normaliser quotients, saturates them, queues the result and issues launch credit.
module norm_result_collector
    import norm_pkg::*;
#(
    parameter int DATAWIDTH = LANE_W,
    parameter int DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     launch,
    output logic                     launch_ok,
    input  logic [3:0]               q_valid,
    input  logic [DATAWIDTH:0]       q_a,
    input  logic [DATAWIDTH:0]       q_b,
    input  logic [DATAWIDTH:0]       q_c,
    input  logic [DATAWIDTH:0]       q_d,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [4*DATAWIDTH-1:0]   m_data,
    output logic [3:0]               m_sat,
    input  logic                     clr_err,
    output logic                     err_mismatch,
    output logic                     err_overflow,
    output logic                     err_credit
);

    localparam int CW = $clog2(DEPTH) + 1;

    lane_q_t          q_lane [NUM_LANES];
    lane_sat_t        lane_s [NUM_LANES];
    logic [3:0]       cap_sat;
    lane_t [3:0]      cap_data;
    norm_result_t     cap_res;
    norm_result_t     head;

    logic             capture;
    logic             partial;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    inflight;

    assign q_lane[0] = q_a;
    assign q_lane[1] = q_b;
    assign q_lane[2] = q_c;
    assign q_lane[3] = q_d;

    assign capture = (q_valid == 4'b1111);
    assign partial = (q_valid != 4'b0000) && !capture;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_s[i]   = sat_lane(q_lane[i]);
        assign cap_sat[i]  = lane_s[i].sat;
        assign cap_data[i] = lane_s[i].data;
    end

    assign cap_res = {cap_sat, cap_data};

    sync_fifo #(
        .WIDTH ($bits(norm_result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture),
        .wr_data (cap_res),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Head is masked while empty so the port reads zero out of reset instead of stale storage.
    assign m_valid = !fifo_empty;
    assign m_data  = fifo_empty ? '0 : head.data;
    assign m_sat   = fifo_empty ? '0 : head.sat;
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            case ({launch, capture})
                2'b10: begin
                    if (inflight != {CW{1'b1}}) begin
                        inflight <= inflight + CW'(1);
                    end
                end
                2'b01: begin
                    if (inflight != '0) begin
                        inflight <= inflight - CW'(1);
                    end
                end
                default: inflight <= inflight;
            endcase
        end
    end

    // Results already queued plus vectors still in the pipe must never exceed the FIFO size.
    assign launch_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_mismatch <= 1'b0;
            err_overflow <= 1'b0;
            err_credit   <= 1'b0;
        end else begin
            err_mismatch <= (err_mismatch && !clr_err) || partial;
            err_overflow <= (err_overflow && !clr_err) || (capture && fifo_full && !pop);
            err_credit   <= (err_credit   && !clr_err) || (launch && !launch_ok);
        end
    end

endmodule

// File: tb/tb_norm_result_collector.sv
// Directed bench for norm_result_collector with a queue-based scoreboard on the result port.
module tb_norm_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        launch;
    logic        launch_ok;
    logic [3:0]  q_valid;
    logic [16:0] q_a, q_b, q_c, q_d;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic [3:0]  m_sat;
    logic        clr_err;
    logic        err_mismatch;
    logic        err_overflow;
    logic        err_credit;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [3:0]  sat;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    norm_result_collector #(.DATAWIDTH(16), .DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .launch       (launch),
        .launch_ok    (launch_ok),
        .q_valid      (q_valid),
        .q_a          (q_a),
        .q_b          (q_b),
        .q_c          (q_c),
        .q_d          (q_d),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_sat        (m_sat),
        .clr_err      (clr_err),
        .err_mismatch (err_mismatch),
        .err_overflow (err_overflow),
        .err_credit   (err_credit)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [16:0] a, input logic [16:0] b, input logic [16:0] c,
                       input logic [16:0] d, input logic [63:0] ed, input logic [3:0] es,
                       input bit store);
        q_a = a; q_b = b; q_c = c; q_d = d;
        q_valid = 4'b1111;
        if (store) exp_q.push_back({es, ed});
        tick();
        q_valid = 4'b0000;
    endtask

    // Monitor: every accepted result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst && m_valid && m_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mon_unexpected: got sat=%0h data=%0h, want no output", m_sat, m_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({m_sat, m_data} !== mon_e) begin
                    n_fail++;
                    $display("FAIL mon_result: got sat=%0h data=%0h, want sat=%0h data=%0h",
                             m_sat, m_data, mon_e.sat, mon_e.data);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; launch = 1'b0; q_valid = 4'b0; m_ready = 1'b0; clr_err = 1'b0;
        q_a = '0; q_b = '0; q_c = '0; q_d = '0;
        tick();
        tick();
        check("rst_m_valid",   m_valid, 1'b0);
        check("rst_launch_ok", launch_ok, 1'b1);
        check("rst_m_data",    m_data, 64'h0);
        check("rst_m_sat",     m_sat, 4'h0);
        check("rst_errs",      {err_mismatch, err_overflow, err_credit}, 3'b000);
        rst = 1'b1;
        tick();

        // single vector, lane A only
        m_ready = 1'b1;
        cap(17'h00B50, 17'h0, 17'h0, 17'h0, 64'h0000_0000_0000_0B50, 4'b0000, 1'b1);
        check("t1_valid",  m_valid, 1'b1);
        check("t1_lane_a", m_data[15:0], 16'h0B50);
        check("t1_sat",    m_sat, 4'b0000);
        tick();
        check("t1_drained", m_valid, 1'b0);

        // lane B overflows
        cap(17'h0, 17'h10001, 17'h0, 17'h0, 64'h0000_0000_FFFF_0000, 4'b0010, 1'b1);
        check("t2_lane_b", m_data[31:16], 16'hFFFF);
        check("t2_sat",    m_sat, 4'b0010);
        tick();

        // credit exhaustion, overflow, drain
        m_ready = 1'b0;
        launch = 1'b1;
        repeat (8) tick();
        launch = 1'b0;
        check("t3_launch_ok_8",  launch_ok, 1'b0);
        check("t3_no_credit_err", err_credit, 1'b0);
        launch = 1'b1;
        tick();
        launch = 1'b0;
        check("t3_credit_err", err_credit, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cap(17'(16 + i), 17'h0, 17'h0, 17'h0, 64'(16 + i), 4'b0000, 1'b1);
        end
        check("t3_full_count",   dut.fifo_count, 4'd8);
        check("t3_launch_ok_full", launch_ok, 1'b0);
        check("t3_no_ovf_yet",   err_overflow, 1'b0);
        cap(17'h001FF, 17'h0, 17'h0, 17'h0, 64'h0, 4'b0000, 1'b0);
        check("t3_overflow",     err_overflow, 1'b1);
        check("t3_inflight_sat0", dut.inflight, 4'd0);
        m_ready = 1'b1;
        repeat (8) tick();
        m_ready = 1'b0;
        check("t3_empty",        m_valid, 1'b0);
        check("t3_launch_ok_back", launch_ok, 1'b1);
        check("t3_all_seen",     exp_q.size(), 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t3_clr", {err_overflow, err_credit}, 2'b00);

        // full FIFO with simultaneous capture and pop
        for (int i = 0; i < 8; i++) begin
            cap(17'(32 + i), 17'h0, 17'h0, 17'h0, 64'(32 + i), 4'b0000, 1'b1);
        end
        check("t4_launch_ok_full", launch_ok, 1'b0);
        m_ready = 1'b1;
        cap(17'h00028, 17'h0, 17'h0, 17'h0, 64'h28, 4'b0000, 1'b1);
        m_ready = 1'b0;
        check("t4_count_kept", dut.fifo_count, 4'd8);
        check("t4_no_ovf",     err_overflow, 1'b0);
        m_ready = 1'b1;
        repeat (8) tick();
        m_ready = 1'b0;
        check("t4_empty",    m_valid, 1'b0);
        check("t4_all_seen", exp_q.size(), 0);

        // partial valid
        q_valid = 4'b0111;
        tick();
        q_valid = 4'b0000;
        check("t5_mismatch", err_mismatch, 1'b1);
        check("t5_no_write", dut.fifo_count, 4'd0);
        clr_err = 1'b1;
        q_valid = 4'b0110;
        tick();
        q_valid = 4'b0000;
        check("t5_event_wins", err_mismatch, 1'b1);
        tick();
        clr_err = 1'b0;
        check("t5_cleared", err_mismatch, 1'b0);

        // asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) begin
            cap(17'(64 + i), 17'h0, 17'h0, 17'h0, 64'(64 + i), 4'b0000, 1'b1);
        end
        launch = 1'b1;
        repeat (2) tick();
        launch = 1'b0;
        check("t6_pre_count",    dut.fifo_count, 4'd3);
        check("t6_pre_inflight", dut.inflight, 4'd2);
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("t6_rst_valid",    m_valid, 1'b0);
        check("t6_rst_launch_ok", launch_ok, 1'b1);
        check("t6_rst_count",    dut.fifo_count, 4'd0);
        check("t6_rst_inflight", dut.inflight, 4'd0);
        tick();
        rst = 1'b1;
        tick();
        m_ready = 1'b1;
        cap(17'h00777, 17'h0, 17'h0, 17'h0, 64'h777, 4'b0000, 1'b1);
        check("t6_late_valid",    m_valid, 1'b1);
        check("t6_late_inflight", dut.inflight, 4'd0);
        tick();
        m_ready = 1'b0;
        check("t6_all_seen", exp_q.size(), 0);
        check("t6_empty",    m_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
